// File: rtl/clk_gen_multi.sv
// Multi-channel divided clock generator with a shared ALIGN/SETTLE/LOCKED controller.
// All channels reload their phase offsets together whenever any channel is reprogrammed.
module clk_gen_multi #(
    parameter int                NUM_CLK     = 4,
    parameter int                DIV_W       = 8,
    parameter int                LOCK_CYCLES = 16,
    parameter logic [DIV_W-1:0]  DEF_DIV     = DIV_W'(4),
    parameter logic [DIV_W-1:0]  DEF_HIGH    = DIV_W'(2),
    parameter logic [DIV_W-1:0]  DEF_PHASE   = DIV_W'(0)
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_sel,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [DIV_W-1:0]   cfg_high,
    input  logic [DIV_W-1:0]   cfg_phase,
    output logic               cfg_err,
    output logic [NUM_CLK-1:0] outclk,
    output logic [NUM_CLK-1:0] clk_en,
    output logic               locked,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ALIGN  = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int             SW          = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(LOCK_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SW-1:0]      r_settle;
    logic [DIV_W-1:0]   r_div   [NUM_CLK];
    logic [DIV_W-1:0]   r_high  [NUM_CLK];
    logic [DIV_W-1:0]   r_phase [NUM_CLK];
    logic [DIV_W-1:0]   r_cnt   [NUM_CLK];
    logic [NUM_CLK-1:0] r_outclk;
    logic [NUM_CLK-1:0] r_clk_en;
    logic               r_locked;
    logic               r_cfg_err;
    logic               w_accept;
    logic               w_bad;
    logic               w_wr;

    // Handshake: a request transfers on any refclk edge where cfg_valid && cfg_ready;
    // cfg_valid while cfg_ready is low is simply not seen.
    assign cfg_ready = !rst && (r_state != ALIGN);
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_bad     = (32'(cfg_sel) >= NUM_CLK) || (cfg_div < DIV_W'(2)) ||
                       (cfg_high == '0) || (cfg_high >= cfg_div) || (cfg_phase >= cfg_div);
    assign w_wr      = w_accept && !w_bad;

    assign outclk    = r_outclk;
    assign clk_en    = r_clk_en;
    assign locked    = r_locked;
    assign cfg_err   = r_cfg_err;
    assign dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ALIGN:   w_state_nxt = SETTLE;
            SETTLE:  if (r_settle == SETTLE_LAST) w_state_nxt = LOCKED;
            LOCKED:  w_state_nxt = LOCKED;
            default: w_state_nxt = ALIGN;
        endcase
        // A successful write always forces a full realignment, even mid-settle.
        if (w_wr) w_state_nxt = ALIGN;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= ALIGN;
            r_settle  <= '0;
            r_outclk  <= '0;
            r_clk_en  <= '0;
            r_locked  <= 1'b0;
            r_cfg_err <= 1'b0;
            for (int i = 0; i < NUM_CLK; i++) begin
                r_div[i]   <= DEF_DIV;
                r_high[i]  <= DEF_HIGH;
                r_phase[i] <= DEF_PHASE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_locked  <= (r_state == LOCKED);
            r_cfg_err <= w_accept && w_bad;
            if (r_state == ALIGN) begin
                r_settle <= '0;
            end else if ((r_state == SETTLE) && (r_settle != SETTLE_LAST)) begin
                r_settle <= r_settle + SW'(1);
            end
            for (int i = 0; i < NUM_CLK; i++) begin
                if (r_state == ALIGN) begin
                    // Counter starts (div - phase) so the first rise lags a phase-0 channel by phase cycles.
                    r_cnt[i]    <= (r_phase[i] == '0) ? '0 : (r_div[i] - r_phase[i]);
                    r_outclk[i] <= 1'b0;
                    r_clk_en[i] <= 1'b0;
                end else begin
                    r_cnt[i]    <= (r_cnt[i] == (r_div[i] - DIV_W'(1))) ? '0 : (r_cnt[i] + DIV_W'(1));
                    r_outclk[i] <= (r_cnt[i] < r_high[i]);
                    r_clk_en[i] <= (r_cnt[i] == '0);
                end
                if (w_wr && (cfg_sel == 3'(i))) begin
                    r_div[i]   <= cfg_div;
                    r_high[i]  <= cfg_high;
                    r_phase[i] <= cfg_phase;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi: a timeline model predicts every output cycle
// and the predictions are queued and popped after each refclk edge.
module tb_clk_gen_multi;

    localparam int NUM_CLK     = 2;
    localparam int DIV_W       = 8;
    localparam int LOCK_CYCLES = 8;
    localparam int W           = 2 * NUM_CLK + 3;

    logic               refclk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [2:0]         cfg_sel = '0;
    logic [DIV_W-1:0]   cfg_div = '0;
    logic [DIV_W-1:0]   cfg_high = '0;
    logic [DIV_W-1:0]   cfg_phase = '0;
    logic               cfg_err;
    logic [NUM_CLK-1:0] outclk;
    logic [NUM_CLK-1:0] clk_en;
    logic               locked;
    logic [1:0]         dbg_state;

    clk_gen_multi #(
        .NUM_CLK(NUM_CLK), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES),
        .DEF_DIV(8'd4), .DEF_HIGH(8'd2), .DEF_PHASE(8'd0)
    ) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .cfg_err(cfg_err), .outclk(outclk), .clk_en(clk_en), .locked(locked),
        .dbg_state(dbg_state)
    );

    // clock
    always #5 refclk = ~refclk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // timeline model: m_t counts edges since the realignment edge
    int  m_div[NUM_CLK];
    int  m_high[NUM_CLK];
    int  m_phase[NUM_CLK];
    int  m_t = -1;
    bit  m_align = 1'b1;

    function automatic logic [W-1:0] model_edge();
        logic [NUM_CLK-1:0] e_out;
        logic [NUM_CLK-1:0] e_en;
        logic e_lock, e_err, e_rdy;
        int start, cnt;
        bit bad;
        e_out = '0; e_en = '0; e_lock = 1'b0; e_err = 1'b0;
        if (rst) begin
            for (int i = 0; i < NUM_CLK; i++) begin
                m_div[i] = 4; m_high[i] = 2; m_phase[i] = 0;
            end
            m_align = 1'b1;
            m_t = -1;
        end else if (m_align) begin
            m_align = 1'b0;
            m_t = 0;
        end else begin
            m_t++;
            for (int i = 0; i < NUM_CLK; i++) begin
                start    = (m_phase[i] == 0) ? 0 : m_div[i] - m_phase[i];
                cnt      = (start + m_t - 1) % m_div[i];
                e_out[i] = (cnt < m_high[i]);
                e_en[i]  = (cnt == 0);
            end
            e_lock = (m_t >= LOCK_CYCLES + 1);
            if (cfg_valid) begin
                bad = (int'(cfg_sel) >= NUM_CLK) || (cfg_div < 2) || (cfg_high == 0) ||
                      (cfg_high >= cfg_div) || (cfg_phase >= cfg_div);
                if (bad) begin
                    e_err = 1'b1;
                end else begin
                    m_div[cfg_sel]   = int'(cfg_div);
                    m_high[cfg_sel]  = int'(cfg_high);
                    m_phase[cfg_sel] = int'(cfg_phase);
                    m_align = 1'b1;
                end
            end
        end
        e_rdy = !rst && !m_align;
        return {e_out, e_en, e_lock, e_err, e_rdy};
    endfunction

    // driver tasks
    task automatic step(input int n);
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model_edge());
            @(posedge refclk);
            #1;
            cyc++;
            got_v = {outclk, clk_en, locked, cfg_err, cfg_ready};
            exp_v = exp_q.pop_front();
            n_checks++;
            assert (got_v === exp_v) else begin
                n_fail++;
                $error("FAIL cyc%0d {outclk,clk_en,locked,err,rdy}: observed %b expected %b",
                       cyc, got_v, exp_v);
            end
        end
    endtask

    task automatic request(input logic [2:0] sel, input int dv, input int hi, input int ph, input int n);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_div   = DIV_W'(dv);
        cfg_high  = DIV_W'(hi);
        cfg_phase = DIV_W'(ph);
        step(n);
        cfg_valid = 1'b0;
    endtask

    initial begin
        // reset hold, then defaults lock
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(20);

        // reprogram channel 1: div 5, high 1, phase 2
        request(3'd1, 5, 1, 2, 1);
        step(22);

        // rejected requests: high == div, then out-of-range select
        request(3'd0, 5, 5, 0, 1);
        step(6);
        request(3'd2, 4, 2, 0, 1);
        step(6);
        request(3'd1, 1, 1, 0, 1);
        step(3);
        request(3'd1, 4, 2, 4, 1);
        step(3);

        // fastest divider, then the widest one
        request(3'd0, 2, 1, 0, 1);
        step(14);
        request(3'd0, 255, 128, 0, 1);
        step(520);

        // reset mid-settle discards runtime configuration
        request(3'd1, 3, 1, 1, 1);
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(14);

        // request held across ALIGN is taken on the first SETTLE edge
        request(3'd0, 6, 3, 1, 1);
        request(3'd1, 3, 2, 2, 2);
        step(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gen_multi.md
CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

Interface
REQ-001 Parameter: NUM_CLK, default 4, number of generated clock channels (1..8).
REQ-002 Parameter: DIV_W, default 8, width of the divide, high-time and phase fields.
REQ-003 Parameter: LOCK_CYCLES, default 16, settle time in refclk cycles before lock (>=1).
REQ-004 Parameters: DEF_DIV, DEF_HIGH and DEF_PHASE, defaults 4, 2 and 0, the reset configuration of every channel.
REQ-005 Port: refclk  in  1  sole clock; all logic on its rising edge.
REQ-006 Port: rst  in  1  synchronous, active-high reset.
REQ-007 Port: cfg_valid  in  1  configuration request.
REQ-008 Port: cfg_ready  out  1  configuration may be accepted this cycle.
REQ-009 Port: cfg_sel  in  3  target channel index.
REQ-010 Port: cfg_div, cfg_high, cfg_phase  in  DIV_W each  period, high time and phase offset, all in refclk cycles.
REQ-011 Port: cfg_err  out  1  one-cycle pulse on a rejected request.
REQ-012 Port: outclk  out  NUM_CLK  generated divided clocks, registered.
REQ-013 Port: clk_en  out  NUM_CLK  one-cycle pulse in the first high cycle of each outclk period, registered.
REQ-014 Port: locked  out  1  all channels are aligned and settled, registered.

Function
REQ-015 The controller SHALL implement the states ALIGN, SETTLE and LOCKED.
REQ-016 In ALIGN, for one cycle, each channel counter SHALL load 0 if its phase is 0, otherwise div-phase; the state SHALL then go to SETTLE with the settle counter at 0.
REQ-017 In SETTLE, the settle counter SHALL increment each cycle; the state SHALL go to LOCKED in the cycle it reaches LOCK_CYCLES-1.
REQ-018 locked SHALL be high only while in LOCKED.
REQ-019 In SETTLE and LOCKED, each channel counter SHALL advance modulo div each cycle.
REQ-020 In SETTLE and LOCKED, outclk[i] SHALL be high exactly in the cycles where counter i is in 0..high-1.
REQ-021 clk_en[i] SHALL be high exactly in the cycles where counter i equals 0.
REQ-022 In ALIGN, outclk and clk_en SHALL be 0.
REQ-023 cfg_ready SHALL be high in SETTLE and LOCKED and low in ALIGN and during rst.
REQ-024 A request SHALL be accepted in a cycle with cfg_valid=1 and cfg_ready=1.
REQ-025 An accepted request SHALL be rejected if any of these hold: cfg_sel>=NUM_CLK; cfg_div<2; cfg_high=0; cfg_high>=cfg_div; cfg_phase>=cfg_div.
REQ-026 On rejection, cfg_err SHALL pulse for one cycle, no configuration SHALL change and the state SHALL be unchanged.
REQ-027 On a valid request, the target channel's div, high and phase SHALL be written; the next state SHALL be ALIGN, realigning all channels; locked SHALL fall the next cycle.
REQ-028 A request with cfg_valid=1 while cfg_ready=0 SHALL be ignored, with no cfg_err.
REQ-029 A valid request during SETTLE SHALL restart alignment and the full settle period.
REQ-030 Counter and field arithmetic SHALL be unsigned in DIV_W bits; div=2^DIV_W-1 SHALL be supported without overflow.

Reset
REQ-031 While rst=1: state=ALIGN, every channel = {DEF_DIV, DEF_HIGH, DEF_PHASE}, settle counter=0, outclk=0, clk_en=0, locked=0, cfg_ready=0, cfg_err=0.
REQ-032 rst asserted mid-SETTLE or mid-LOCKED SHALL discard all runtime configuration.
REQ-033 After rst is released, the first edge SHALL execute ALIGN; locked SHALL rise LOCK_CYCLES+1 cycles after that edge.

Verification (NUM_CLK=2, DIV_W=8, LOCK_CYCLES=8)
REQ-034 Release rst -> locked=0 for 9 cycles then 1; each outclk shows 1100 repeating; clk_en pulses every 4 cycles on the first 1.
REQ-035 In LOCKED, send sel=1, div=5, high=1, phase=2 -> cfg_ready=1 handshake; locked=0 the next cycle; outclk=00 for one cycle; ch1 shows 00010 repeating; ch0 keeps 1100; locked=1 after 9 cycles.
REQ-036 Send div=5, high=5 or sel=2 -> cfg_err one-cycle pulse; locked stays 1; both waveforms unchanged.
REQ-037 Send div=2, high=1 then div=255, high=128 -> outclk toggles every cycle, then a 128-high/127-low period with no wrap error.
REQ-038 Assert rst for 1 cycle mid-SETTLE after a reconfiguration -> defaults restored (1100 on both channels); lock timing per REQ-033.
REQ-039 Hold cfg_valid=1 during ALIGN -> not accepted, no cfg_err; the request is accepted in the first SETTLE cycle.
